// File: rtl/pe_mac_unit.sv
// Systolic processing element: forwards A/B operands east/south with one cycle of latency
// and accumulates a signed dot product of programmable length. Multiply and accumulate are
// two registered stages.
// Optional feature: define SATURATE_EN to clamp the accumulator on overflow instead of
// letting it wrap.
module pe_mac_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  valid_o,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  res_valid_o,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
`ifdef SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e                       state_q;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [LEN_WIDTH-1:0]         issued_q;
  logic [LEN_WIDTH-1:0]         done_cnt_q;
  logic signed [PW-1:0]         p_q;
  logic                         pv_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic                         ovf_q;
  logic                         res_valid_q;

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  p_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic                         add_ovf;
  logic                         take_term;
  logic                         last_add;

  assign a_s  = a_i;
  assign b_s  = b_i;
  // Operands are sign-extended before the multiply so the full-width product is exact.
  assign prod = PW'(a_s) * PW'(b_s);

  // Stage-2 adder with signed overflow detection and optional clamping.
  always_comb begin
    p_ext    = ACC_WIDTH'(p_q);
    acc_sum  = acc_q + p_ext;
    add_ovf  = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_next = acc_sum;
`ifdef SATURATE_EN
    if (add_ovf) begin
      acc_next = acc_q[ACC_WIDTH-1] ? AccMin : AccMax;
    end
`endif
  end

  assign take_term = valid_i && (issued_q < len_q);
  assign last_add  = (done_cnt_q + LEN_WIDTH'(1)) == len_q;

  // Operand forwarding to neighbours, independent of the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_o     <= '0;
      b_o     <= '0;
      valid_o <= 1'b0;
    end else begin
      a_o     <= a_i;
      b_o     <= b_i;
      valid_o <= valid_i;
    end
  end

  // Control FSM plus multiply and accumulate pipeline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      len_q       <= '0;
      issued_q    <= '0;
      done_cnt_q  <= '0;
      p_q         <= '0;
      pv_q        <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      pv_q        <= 1'b0;
      if (clear_i) begin
        // Restart from any state; an in-flight product is dropped because pv_q is rewritten.
        acc_q      <= '0;
        ovf_q      <= 1'b0;
        done_cnt_q <= '0;
        len_q      <= len_i;
        if (len_i == '0) begin
          state_q     <= StDone;
          res_valid_q <= 1'b1;
          issued_q    <= '0;
        end else begin
          state_q <= StAcc;
          if (valid_i) begin
            p_q      <= prod;
            pv_q     <= 1'b1;
            issued_q <= LEN_WIDTH'(1);
          end else begin
            issued_q <= '0;
          end
        end
      end else begin
        unique case (state_q)
          StIdle: ;
          StAcc: begin
            if (take_term) begin
              p_q      <= prod;
              pv_q     <= 1'b1;
              issued_q <= issued_q + LEN_WIDTH'(1);
            end
            if (pv_q) begin
              acc_q      <= acc_next;
              ovf_q      <= ovf_q | add_ovf;
              done_cnt_q <= done_cnt_q + LEN_WIDTH'(1);
              if (last_add) begin
                state_q     <= StDone;
                res_valid_q <= 1'b1;
              end
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign res_o       = acc_q;
  assign res_valid_o = res_valid_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q == StAcc);

endmodule

// File: tb/tb_pe_mac_unit.sv
// Directed bench for pe_mac_unit, built with a 16-bit accumulator so the overflow case bites.
module tb_pe_mac_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [LW-1:0] len;
  logic          valid;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          valid_out;
  logic [AW-1:0] res;
  logic          res_valid;
  logic          ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  pe_mac_unit #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .len_i      (len),
    .valid_i    (valid),
    .a_i        (a),
    .b_i        (b),
    .a_o        (a_out),
    .b_o        (b_out),
    .valid_o    (valid_out),
    .res_o      (res),
    .res_valid_o(res_valid),
    .overflow_o (ovf),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, then advance past the next rising edge.
  task automatic step(input logic clr, input int ln, input logic v, input int av, input int bv);
    clear = clr;
    len   = LW'(ln);
    valid = v;
    a     = DW'(av);
    b     = DW'(bv);
    @(posedge clk);
    #1;
  endtask

  function automatic int sres();
    return int'($signed(res));
  endfunction

  initial begin
    // Reset with live inputs.
    rst = 1'b1;
    step(0, 0, 1, 5, 0);
    step(0, 0, 1, 5, 0);
    check("rst a_o", int'(a_out), 0);
    check("rst valid_o", int'(valid_out), 0);
    check("rst res_o", sres(), 0);
    check("rst res_valid", int'(res_valid), 0);
    check("rst overflow", int'(ovf), 0);
    check("rst busy", int'(busy), 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("idle res_o", sres(), 0);
    check("idle busy", int'(busy), 0);

    // Basic dot product: 6 - 20 - 7 = -21.
    step(1, 3, 1, 2, 3);
    check("basic busy", int'(busy), 1);
    check("basic a_o", int'($signed(a_out)), 2);
    check("basic b_o", int'($signed(b_out)), 3);
    step(0, 0, 1, -4, 5);
    check("basic a_o2", int'($signed(a_out)), -4);
    step(0, 0, 1, 7, -1);
    check("basic b_o3", int'($signed(b_out)), -1);
    check("basic early rv", int'(res_valid), 0);
    step(0, 0, 0, 0, 0);
    check("basic res_valid", int'(res_valid), 1);
    check("basic res_o", sres(), -21);
    check("basic done busy", int'(busy), 0);
    step(0, 0, 0, 0, 0);
    check("basic rv pulse", int'(res_valid), 0);
    check("basic hold", sres(), -21);

    // Gapped input: 16129 + 16384 = 32513.
    step(1, 2, 1, 127, 127);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("gap busy", int'(busy), 1);
    end
    step(0, 0, 1, -128, -128);
    check("gap busy2", int'(busy), 1);
    step(0, 0, 0, 0, 0);
    check("gap res_valid", int'(res_valid), 1);
    check("gap res_o", sres(), 32513);
    check("gap overflow", int'(ovf), 0);

    // Excess terms are ignored once len terms are issued.
    step(1, 2, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    check("excess res_valid", int'(res_valid), 1);
    check("excess res_o", sres(), 2);
    step(0, 0, 1, 1, 1);
    check("excess rv pulse", int'(res_valid), 0);
    step(0, 0, 0, 0, 0);
    check("excess hold", sres(), 2);

    // Zero length goes straight to DONE.
    step(1, 0, 0, 0, 0);
    check("zero res_valid", int'(res_valid), 1);
    check("zero res_o", sres(), 0);
    check("zero busy", int'(busy), 0);
    step(0, 0, 0, 0, 0);
    check("zero rv pulse", int'(res_valid), 0);

    // Restart mid-accumulation: partial 25 and in-flight 25 are discarded.
    step(1, 3, 1, 5, 5);
    step(0, 0, 1, 5, 5);
    step(1, 1, 1, 3, 3);
    check("restart cleared", sres(), 0);
    check("restart busy", int'(busy), 1);
    step(0, 0, 0, 0, 0);
    check("restart res_valid", int'(res_valid), 1);
    check("restart res_o", sres(), 9);

    // Overflow: 3 * 16129 = 48387 exceeds 32767.
    step(1, 3, 1, 127, 127);
    step(0, 0, 1, 127, 127);
    step(0, 0, 1, 127, 127);
    check("ovf partial", sres(), 32258);
    check("ovf not yet", int'(ovf), 0);
    step(0, 0, 0, 0, 0);
    check("ovf res_valid", int'(res_valid), 1);
`ifdef SATURATE_EN
    check("ovf res_o sat", sres(), 32767);
`else
    check("ovf res_o wrap", sres(), -17149);
`endif
    check("ovf flag", int'(ovf), 1);
    step(0, 0, 0, 0, 0);
    check("ovf sticky", int'(ovf), 1);
    step(1, 0, 0, 0, 0);
    check("ovf cleared", int'(ovf), 0);
    check("ovf clear res", sres(), 0);

    // Reset dominates an accumulation in progress.
    step(1, 2, 1, 1, 1);
    rst = 1'b1;
    step(0, 0, 1, 1, 1);
    check("mid rst busy", int'(busy), 0);
    check("mid rst res_o", sres(), 0);
    check("mid rst valid_o", int'(valid_out), 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    check("post rst res_o", sres(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
